// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 constants, opcodes and the fetch buffer entry type
package riscv_pkg;

    localparam int              XLEN     = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous instruction buffer with flush; flush beats push/pop
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - in-order instruction fetch with redirect flush; FETCH_MISALIGN_CHK_EN adds sticky misalign halt
module fetch_unit #(
    parameter int              XLEN       = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = riscv_pkg::RESET_PC,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_data_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic [XLEN-1:0] instr_pc_plus4_o,
    output logic [6:0]      op_o,
    output logic [2:0]      funct3_o,
    output logic            funct7b5_o
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic            misalign_o
`endif
);

    import riscv_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credit_used;
    logic            active;
    logic            halted;
    logic            fifo_full;
    logic            fifo_empty;
    logic            req_fire;
    logic            push;
    logic            pop;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    assign credit_used      = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req_valid_o = active && !halted && !redirect_i && !fifo_full &&
                              (drop_cnt == '0) && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr_o  = pc;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;

    // With nothing left to drop, live requests are consecutive words ending at pc-4.
    assign push_entry.instr = imem_rsp_data_i;
    assign push_entry.pc    = pc - (XLEN'(outstanding) << 2);
    assign push             = imem_rsp_valid_i && (drop_cnt == '0) && !redirect_i;
    assign pop              = instr_valid_o && instr_ready_i;

`ifdef FETCH_MISALIGN_CHK_EN
    assign target = redirect_pc_i;
    assign halted = misalign_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_o <= 1'b0;
        end else if (redirect_i && (redirect_pc_i[1:0] != 2'b00)) begin
            misalign_o <= 1'b1;
        end
    end
`else
    assign target = redirect_pc_i & ~XLEN'(3);
    assign halted = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            active      <= 1'b0;
        end else begin
            active <= 1'b1;
            if (redirect_i) begin
                // A response landing this cycle is already discarded, so it is not counted again.
                pc          <= target;
                outstanding <= outstanding - CW'(imem_rsp_valid_i);
                drop_cnt    <= outstanding - CW'(imem_rsp_valid_i);
            end else begin
                if (req_fire) begin
                    pc <= pc + XLEN'(4);
                end
                outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid_i);
                if (imem_rsp_valid_i && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_i),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign instr_valid_o    = !fifo_empty && !halted;
    assign instr_o          = head.instr;
    assign instr_pc_o       = head.pc;
    assign instr_pc_plus4_o = instr_pc_o + XLEN'(4);
    assign op_o             = instr_o[6:0];
    assign funct3_o         = instr_o[14:12];
    assign funct7b5_o       = instr_o[30];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized scoreboard bench for fetch_unit
`timescale 1ns/1ps
module tb_fetch_unit;

    import riscv_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic [31:0] instr_pc_plus4_o;
    logic [6:0]  op_o;
    logic [2:0]  funct3_o;
    logic        funct7b5_o;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        misalign_o;
`endif

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN       (32),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .instr_valid_o    (instr_valid_o),
        .instr_ready_i    (instr_ready_i),
        .instr_o          (instr_o),
        .instr_pc_o       (instr_pc_o),
        .instr_pc_plus4_o (instr_pc_plus4_o),
        .op_o             (op_o),
        .funct3_o         (funct3_o),
        .funct7b5_o       (funct7b5_o)
`ifdef FETCH_MISALIGN_CHK_EN
        ,
        .misalign_o       (misalign_o)
`endif
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          req_mode = 0;
    int          dec_mode = 1;
    bit          rand_redir = 1'b0;
    int          redir_seq = 0;
    int          redir_done = 0;
    logic [31:0] redir_tgt = 32'h0;
    int          arm_seq = 0;
    int          arm_done = 0;
    logic [31:0] arm_tgt = 32'h0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_req;
    int          delivered = 0;
    int          req_since = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        logic [6:0]  op;
        h = (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
        case (a[4:2])
            3'd0:    op = OP_R;
            3'd1:    op = OP_I;
            3'd2:    op = OP_LOAD;
            3'd3:    op = OP_STORE;
            3'd4:    op = OP_BRANCH;
            3'd5:    op = OP_JAL;
            default: op = OP_I;
        endcase
        return {h[31:7], op};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference program stream: after a (re)start at t the decoder must see t, t+4, t+8, ...
    task automatic load_stream(input logic [31:0] t);
        exp_q.delete();
        for (int k = 0; k < 1024; k++) begin
            exp_q.push_back(t + 32'(4 * k));
        end
        exp_req = t;
    endtask

    // Memory model and input driver
    initial begin : driver
        int t;
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = 32'h0;
        instr_ready_i    = 1'b0;
        redirect_i       = 1'b0;
        redirect_pc_i    = 32'h0;
        forever begin
            @(negedge clk);
            if (rst_n && imem_req_valid_o && imem_req_ready_i) begin
                mq.push_back('{addr: imem_req_addr_o,
                               due: cyc + int'($urandom_range(lat_max, lat_min))});
            end
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                mq.delete();
                imem_rsp_valid_i = 1'b0;
                imem_req_ready_i = 1'b0;
                instr_ready_i    = 1'b0;
                redirect_i       = 1'b0;
                continue;
            end
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem_rsp_valid_i = 1'b1;
                imem_rsp_data_i  = mem_word(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                imem_rsp_valid_i = 1'b0;
                imem_rsp_data_i  = $urandom;
            end
            case (req_mode)
                0:       imem_req_ready_i = 1'b1;
                1:       imem_req_ready_i = ~imem_req_ready_i;
                default: imem_req_ready_i = 1'($urandom_range(1, 0));
            endcase
            case (dec_mode)
                0:       instr_ready_i = 1'b0;
                1:       instr_ready_i = 1'b1;
                default: instr_ready_i = 1'($urandom_range(1, 0));
            endcase
            redirect_i    = 1'b0;
            redirect_pc_i = $urandom;
            if (redir_done != redir_seq) begin
                redirect_i    = 1'b1;
                redirect_pc_i = redir_tgt;
                redir_done    = redir_seq;
            end else if (arm_done != arm_seq && imem_rsp_valid_i && instr_ready_i && instr_valid_o) begin
                redirect_i    = 1'b1;
                redirect_pc_i = arm_tgt;
                arm_done      = arm_seq;
            end else if (rand_redir && $urandom_range(24, 0) == 0) begin
                t             = int'($urandom_range(9, 0));
                redirect_i    = 1'b1;
                redirect_pc_i = (t == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
            end
        end
    end

    // Monitor / scoreboard
    initial begin : monitor
        logic [31:0] e;
        logic [31:0] w;
        bit          prev_redir;
        bit          mis_exp;
        prev_redir = 1'b0;
        mis_exp    = 1'b0;
        exp_req    = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_req_valid", 32'(imem_req_valid_o), 32'h0);
                check("rst_instr_valid", 32'(instr_valid_o), 32'h0);
                check("rst_instr", instr_o, 32'h0);
                check("rst_instr_pc", instr_pc_o, 32'h0);
`ifdef FETCH_MISALIGN_CHK_EN
                check("rst_misalign", 32'(misalign_o), 32'h0);
`endif
                load_stream(32'h0);
                prev_redir = 1'b0;
                mis_exp    = 1'b0;
                continue;
            end
            if (prev_redir) begin
                check("flush_empty", 32'(instr_valid_o), 32'h0);
            end
`ifdef FETCH_MISALIGN_CHK_EN
            if (mis_exp) begin
                check("misalign_sticky", 32'(misalign_o), 32'h1);
                check("halt_no_instr", 32'(instr_valid_o), 32'h0);
                check("halt_no_req", 32'(imem_req_valid_o), 32'h0);
            end
`endif
            if (instr_valid_o && instr_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("stream_underflow", 32'h1, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    w = mem_word(e);
                    check("instr_pc", instr_pc_o, e);
                    check("instr", instr_o, w);
                    check("pc_plus4", instr_pc_plus4_o, e + 32'd4);
                    check("fields", 32'({op_o, funct3_o, funct7b5_o}),
                          32'({w[6:0], w[14:12], w[30]}));
                    delivered++;
                end
            end
            if (imem_req_valid_o && imem_req_ready_i) begin
                check("req_addr", imem_req_addr_o, exp_req);
                exp_req = exp_req + 32'd4;
                req_since++;
            end
            if (redirect_i) begin
                check("redir_no_req", 32'(imem_req_valid_o), 32'h0);
`ifdef FETCH_MISALIGN_CHK_EN
                load_stream(redirect_pc_i);
                if (redirect_pc_i[1:0] != 2'b00) begin
                    mis_exp = 1'b1;
                end
`else
                load_stream(redirect_pc_i & ~32'd3);
`endif
                req_since  = 0;
                prev_redir = 1'b1;
            end else begin
                prev_redir = 1'b0;
            end
        end
    end

    initial begin : main
        int  d0;
        int  r0;
        bit  found;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // Straight-line fetch, latency 1, everything ready
        d0 = delivered;
        repeat (40) @(posedge clk);
        check("p1_progress", 32'(delivered - d0 >= 10), 32'h1);

        // Decode stalled: only FIFO_DEPTH requests may be accepted
        @(posedge clk);
        #3;
        dec_mode  = 0;
        redir_tgt = 32'h40;
        redir_seq++;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("hold_req_count", 32'(req_since), 32'(DEPTH));
        check("hold_req_valid", 32'(imem_req_valid_o), 32'h0);
        check("hold_instr_valid", 32'(instr_valid_o), 32'h1);
        r0 = req_since;
        d0 = delivered;
        @(posedge clk);
        #3 dec_mode = 1;
        repeat (30) @(posedge clk);
        check("resume_req", 32'(req_since > r0), 32'h1);
        check("resume_drain", 32'(delivered - d0 >= 8), 32'h1);

        // Request ready toggling each cycle
        #3 req_mode = 1;
        d0 = delivered;
        repeat (60) @(posedge clk);
        check("toggle_progress", 32'(delivered - d0 >= 8), 32'h1);

        // Redirect with two requests in flight
        #3;
        req_mode = 0;
        lat_min  = 3;
        lat_max  = 3;
        found    = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk);
            #3;
            if (mq.size() == 2) found = 1'b1;
        end
        check("two_outstanding_seen", 32'(found), 32'h1);
        redir_tgt = 32'h100;
        redir_seq++;
        d0 = delivered;
        repeat (30) @(posedge clk);
        check("redir100_progress", 32'(delivered - d0 >= 4), 32'h1);

        // Redirect coinciding with a response and a decode handshake
        #3;
        lat_min = 1;
        lat_max = 2;
        arm_tgt = 32'h200;
        arm_seq++;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk);
            #3;
            if (arm_done == arm_seq) found = 1'b1;
        end
        check("coincident_redirect_hit", 32'(found), 32'h1);
        repeat (20) @(posedge clk);

        // Wraparound target, then randomized traffic with random redirects
        #3;
        redir_tgt = 32'hFFFF_FFF8;
        redir_seq++;
        repeat (20) @(posedge clk);
        #3;
        lat_min    = 1;
        lat_max    = 3;
        req_mode   = 2;
        dec_mode   = 2;
        rand_redir = 1'b1;
        d0 = delivered;
        repeat (1500) @(posedge clk);
        #3 rand_redir = 1'b0;
        check("random_progress", 32'(delivered - d0 >= 100), 32'h1);

        // Reset in the middle of traffic
        @(posedge clk);
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n    = 1'b1;
        req_mode = 0;
        dec_mode = 1;
        lat_min  = 1;
        lat_max  = 1;
        d0 = delivered;
        repeat (40) @(posedge clk);
        check("post_reset_progress", 32'(delivered - d0 >= 10), 32'h1);

        // Misaligned redirect target
        #3;
        redir_tgt = 32'h102;
        redir_seq++;
        d0 = delivered;
        repeat (20) @(posedge clk);
        @(negedge clk);
`ifdef FETCH_MISALIGN_CHK_EN
        check("misalign_set", 32'(misalign_o), 32'h1);
        check("misalign_no_delivery", 32'(delivered - d0), 32'h0);
`else
        check("misalign_forced_align", 32'(delivered - d0 >= 5), 32'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
